// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI-slave command engine driving the SB_SPI hard-IP system bus.
// It configures the IP, waits for a sync byte, then handles fixed-length command
// frames and returns one reply byte for each received byte.
// Optional feature: define SPI_CMD_TIMEOUT_EN to abort partial frames after an
// inter-byte gap of TIMEOUT_CYCLES clocks.
module spi_cmd_slave #(
  parameter int unsigned CMD_LEN        = 8,
  parameter int unsigned VEC_DEPTH      = 16,
  parameter int unsigned NUM_LEDS       = 3,
  parameter bit          LSB_FIRST      = 1'b1,
  parameter logic [7:0]  SYNC_BYTE      = 8'h11,
  parameter logic [7:0]  REPLY_HDR      = 8'h40,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  output logic                sb_stb,
  output logic                sb_rw,
  output logic [7:0]          sb_adr,
  output logic [7:0]          sb_wdata,
  input  logic [7:0]          sb_rdata,
  input  logic                sb_ack,
  output logic [NUM_LEDS-1:0] led,
  output logic                synced,
  output logic                frame_done,
  output logic [7:0]          err_count
);

  localparam int unsigned PW = $clog2(CMD_LEN);
  localparam int unsigned AW = $clog2(VEC_DEPTH);

  localparam logic [7:0] ADR_SPICR0  = 8'h08;
  localparam logic [7:0] ADR_SPICR1  = 8'h09;
  localparam logic [7:0] ADR_SPICR2  = 8'h0A;
  localparam logic [7:0] ADR_SPIBR   = 8'h0B;
  localparam logic [7:0] ADR_SPISR   = 8'h0C;
  localparam logic [7:0] ADR_SPITXDR = 8'h0D;
  localparam logic [7:0] ADR_SPIRXDR = 8'h0E;
  localparam logic [7:0] ADR_SPICSR  = 8'h0F;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_INIT      = 8'h01;
  localparam logic [7:0] OP_WR_INV    = 8'h02;
  localparam logic [7:0] OP_WR_LEDS   = 8'h04;
  localparam logic [7:0] OP_WR_VEC    = 8'h06;
  localparam logic [7:0] OP_RD_VEC    = 8'h07;
  localparam logic [7:0] OP_RD_STATUS = 8'h08;

  // Reject parameter values outside the supported ranges at elaboration
  if (CMD_LEN < 3 || CMD_LEN > 16 || VEC_DEPTH < 2 || VEC_DEPTH > 256 ||
      (VEC_DEPTH & (VEC_DEPTH - 1)) != 0 || NUM_LEDS < 1 || NUM_LEDS > 8 ||
      TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("spi_cmd_slave: parameter out of range");
  end

  typedef enum logic [3:0] {
    CFG_CR0, CFG_CR1, CFG_CR2, CFG_BR, CFG_CSR,
    POLL_RX, POLL_TX, TX_WR, RD_RX, PROCESS
  } state_t;

  state_t state_q, state_n, bus_next;

  logic                stb_n, rw_n;
  logic [7:0]          adr_n, wdata_n;
  logic                bus_rw;
  logic [7:0]          bus_adr, bus_wdata;
  logic                rx_load;

  logic [7:0]          rx_q;
  logic [PW-1:0]       pos_q, pos_n;
  logic [7:0]          op_q, op_n, op_eff;
  logic [AW-1:0]       addr_q, addr_n;
  logic [NUM_LEDS-1:0] led_pend_q, led_pend_n, led_n;
  logic [7:0]          reply_q, reply_n;
  logic                synced_n, done_n;
  logic [7:0]          err_n;
  logic                proc;
  logic                timeout_c;

  logic [7:0]          vec [VEC_DEPTH];
  logic                vec_we;
  logic [AW-1:0]       rd_base, rd_idx, wr_idx;

  assign proc    = (state_q == PROCESS);
  assign op_eff  = (pos_q == '0) ? rx_q : op_q;
  assign rd_base = (pos_q == PW'(1)) ? rx_q[AW-1:0] : addr_q;
  assign rd_idx  = rd_base + AW'(pos_q - PW'(1));
  assign wr_idx  = addr_q + AW'(pos_q - PW'(2));

  // Bus access descriptor for the current state and the state that follows its ack
  always_comb begin
    bus_rw    = 1'b0;
    bus_adr   = ADR_SPISR;
    bus_wdata = 8'h00;
    bus_next  = state_q;
    case (state_q)
      CFG_CR0: begin bus_rw = 1'b1; bus_adr = ADR_SPICR0; bus_next = CFG_CR1; end
      CFG_CR1: begin bus_rw = 1'b1; bus_adr = ADR_SPICR1; bus_wdata = 8'h80; bus_next = CFG_CR2; end
      CFG_CR2: begin bus_rw = 1'b1; bus_adr = ADR_SPICR2; bus_wdata = {7'b0, LSB_FIRST}; bus_next = CFG_BR; end
      CFG_BR:  begin bus_rw = 1'b1; bus_adr = ADR_SPIBR; bus_next = CFG_CSR; end
      CFG_CSR: begin bus_rw = 1'b1; bus_adr = ADR_SPICSR; bus_next = POLL_RX; end
      POLL_RX: if (sb_rdata[3]) bus_next = synced ? POLL_TX : RD_RX;
      POLL_TX: if (sb_rdata[4]) bus_next = TX_WR;
      TX_WR:   begin bus_rw = 1'b1; bus_adr = ADR_SPITXDR; bus_wdata = reply_q; bus_next = RD_RX; end
      RD_RX:   begin bus_adr = ADR_SPIRXDR; bus_next = PROCESS; end
      default: ;
    endcase
  end

  // Next state and bus strobe: raise stb from idle, hold until ack, then drop for a cycle
  always_comb begin
    state_n = state_q;
    stb_n   = sb_stb;
    rw_n    = sb_rw;
    adr_n   = sb_adr;
    wdata_n = sb_wdata;
    rx_load = 1'b0;
    if (proc) begin
      state_n = POLL_RX;
    end else if (!sb_stb) begin
      stb_n   = 1'b1;
      rw_n    = bus_rw;
      adr_n   = bus_adr;
      wdata_n = bus_wdata;
    end else if (sb_ack) begin
      stb_n   = 1'b0;
      state_n = bus_next;
      rx_load = (state_q == RD_RX);
    end
  end

  // Byte processing: sync detection, opcode decode, reply for the next position, frame end
  always_comb begin
    pos_n      = pos_q;
    op_n       = op_q;
    addr_n     = addr_q;
    led_pend_n = led_pend_q;
    reply_n    = reply_q;
    led_n      = led;
    synced_n   = synced;
    err_n      = err_count;
    done_n     = 1'b0;
    vec_we     = 1'b0;
    if (proc) begin
      if (!synced) begin
        if (rx_q == SYNC_BYTE) begin
          synced_n = 1'b1;
          pos_n    = '0;
          reply_n  = REPLY_HDR;
        end
      end else begin
        if (pos_q == '0) op_n = rx_q;
        if (pos_q == PW'(1)) begin
          addr_n     = rx_q[AW-1:0];
          led_pend_n = rx_q[NUM_LEDS-1:0];
        end
        case (op_eff)
          OP_NOP, OP_INIT: reply_n = 8'h00;
          OP_WR_INV:       reply_n = (pos_q == '0) ? rx_q : ~rx_q;
          OP_WR_LEDS:      reply_n = rx_q;
          OP_WR_VEC: begin
            reply_n = rx_q;
            vec_we  = (pos_q >= PW'(2));
          end
          OP_RD_VEC:       reply_n = (pos_q == '0) ? rx_q : vec[rd_idx];
          OP_RD_STATUS: begin
            case (pos_q)
              PW'(0):  reply_n = err_count;
              PW'(1):  reply_n = {synced, 7'b0};
              PW'(2):  reply_n = 8'(led);
              default: reply_n = 8'h00;
            endcase
          end
          default: begin
            reply_n = 8'h00;
            if (pos_q == '0 && err_count != 8'hFF) err_n = err_count + 8'd1;
          end
        endcase
        if (pos_q == PW'(CMD_LEN - 1)) begin
          pos_n   = '0;
          done_n  = 1'b1;
          reply_n = REPLY_HDR;
          if (op_q == OP_WR_LEDS) led_n = led_pend_q;
          if (op_q == OP_INIT) synced_n = 1'b0;
        end else begin
          pos_n = pos_q + PW'(1);
        end
      end
    end else if (timeout_c) begin
      // Abandon the partial frame; clearing the opcode drops any pending LED commit
      pos_n   = '0;
      op_n    = OP_NOP;
      reply_n = REPLY_HDR;
      if (err_count != 8'hFF) err_n = err_count + 8'd1;
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] gap_q;

  // Inter-byte gap counter inside a partial frame; each received byte restarts it
  always_ff @(posedge clk) begin
    if (reset || proc || !synced || pos_q == '0 || timeout_c) gap_q <= '0;
    else                                                      gap_q <= gap_q + TW'(1);
  end

  assign timeout_c = synced && (pos_q != '0) && !proc && (gap_q == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_c = 1'b0;
`endif

  // State, bus outputs and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CFG_CR0;
      sb_stb     <= 1'b0;
      sb_rw      <= 1'b0;
      sb_adr     <= 8'h00;
      sb_wdata   <= 8'h00;
      rx_q       <= 8'h00;
      pos_q      <= '0;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      led_pend_q <= '0;
      reply_q    <= REPLY_HDR;
      led        <= '0;
      synced     <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      state_q    <= state_n;
      sb_stb     <= stb_n;
      sb_rw      <= rw_n;
      sb_adr     <= adr_n;
      sb_wdata   <= wdata_n;
      if (rx_load) rx_q <= sb_rdata;
      pos_q      <= pos_n;
      op_q       <= op_n;
      addr_q     <= addr_n;
      led_pend_q <= led_pend_n;
      reply_q    <= reply_n;
      led        <= led_n;
      synced     <= synced_n;
      frame_done <= done_n;
      err_count  <= err_n;
    end
  end

  // Vector memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && vec_we) vec[wr_idx] <= rx_q;
  end

endmodule

// File: doc/spi_cmd_slave.md
Name: spi_cmd_slave

Overview:
- Parametrised SPI-slave command engine that drives the SB_SPI hard-IP system bus. The top level instantiates SB_SPI and connects its SBxxx pins to this block.
- Configures the IP, waits for a sync byte, then processes fixed-length command frames from the host. Returns one reply byte per received byte.
- Generalises the single-purpose SPI top: frame length, vector depth, LED count and bit order are parameters. Adds addressed vector access with wrap, a status read, and error counting.

Parameters:
- CMD_LEN, 8: bytes per frame, opcode included; legal range 3..16.
- VEC_DEPTH, 16: bytes of vector memory; power of two, 2..256.
- NUM_LEDS, 3: width of the led output, 1..8.
- LSB_FIRST, 1: value written to SPICR2 bit0.
- SYNC_BYTE, 8'h11: byte that moves the block from unsynced to synced.
- REPLY_HDR, 8'h40: reply byte sent at frame position 0.
- TIMEOUT_CYCLES, 65535: inter-byte gap limit; used only with SPI_CMD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, also drives SBCLKI
- reset  input  1  synchronous, active-high reset
- sb_stb  output  1  to SBSTBI
- sb_rw  output  1  to SBRWI; 1 = write
- sb_adr  output  8  to SBADRI[7:0]
- sb_wdata  output  8  to SBDATI[7:0]
- sb_rdata  input  8  from SBDATO[7:0]
- sb_ack  input  1  from SBACKO
- led  output  NUM_LEDS  active-high LED value; the top inverts it for the pins
- synced  output  1  high once SYNC_BYTE has been received
- frame_done  output  1  one-cycle pulse when the last byte of a frame is processed
- err_count  output  8  saturating count of bad opcodes and timeouts

Behaviour:
- Reset: all outputs go to 0 on the cycle after reset is sampled high, and the FSM goes to CFG_CR0. This applies mid-transfer too: sb_stb drops at once and the pending access is abandoned. Vector memory is not cleared.
- Bus access rule: hold sb_adr, sb_wdata, sb_rw and sb_stb=1 until sb_ack=1. On the ack cycle, sample sb_rdata and drive sb_stb=0 for at least one cycle. Only one access is outstanding at a time.
- Configuration states, each one write:
  - CFG_CR0: 0x08 <- 0x00
  - CFG_CR1: 0x09 <- 0x80
  - CFG_CR2: 0x0A <- {7'b0, LSB_FIRST}
  - CFG_BR: 0x0B <- 0x00
  - CFG_CSR: 0x0F <- 0x00
  - then go to POLL_RX.
- POLL_RX: read SPISR (0x0C) until bit3 (RRDY) = 1. If synced=1, go to POLL_TX; otherwise go to RD_RX.
- POLL_TX: read SPISR until bit4 (TRDY) = 1, then go to TX_WR.
- TX_WR: write SPITXDR (0x0D) with reply[pos], then go to RD_RX.
- RD_RX: read SPIRXDR (0x0E), then go to PROCESS. While unsynced, a byte equal to SYNC_BYTE sets synced=1 and pos=0; any other byte is dropped.
- PROCESS: takes one cycle and handles byte b at position pos. Byte 0 latches the opcode. Then pos increments; at pos = CMD_LEN-1, pos wraps to 0 and frame_done pulses. Then go to POLL_RX.
- Reply pipeline: reply[0] = REPLY_HDR. reply[p], for p >= 1, is computed in PROCESS from byte p-1 of the same frame.
- Opcode 0x00 NOP: reply = 0x00.
- Opcode 0x01 INIT: clears synced at frame end.
- Opcode 0x02 WR_INV: reply = ~b, for all bytes after the opcode.
- Opcode 0x04 WR_LEDS: reply = b (echo). At frame end, led <= byte1[NUM_LEDS-1:0]; the LED value is committed only at frame end.
- Opcode 0x06 WR_VEC: byte1 = address A. Byte k (k >= 2) is written to vec[(A+k-2) mod VEC_DEPTH]. Reply = b.
- Opcode 0x07 RD_VEC: byte1 = address A. Reply[p] for p >= 2 is vec[(A+p-2) mod VEC_DEPTH], a combinational read using the just-latched A. Reply[1] = the opcode.
- Opcode 0x08 RD_STATUS: reply[1] = err_count, reply[2] = {synced, 7'b0}, reply[3] = led zero-extended. Remaining reply bytes are 0x00.
- Other opcodes: every reply byte in the frame is 0x00, and err_count increments once at byte 0.
- Address wrap: all vector address arithmetic is modulo VEC_DEPTH, and addresses >= VEC_DEPTH are truncated to the low bits.
- err_count saturates at 0xFF.
- If reset and frame end fall on the same cycle, reset wins: no LED commit, no frame_done pulse.

Optional Feature:
- Macro SPI_CMD_TIMEOUT_EN, when defined: a gap counter runs while synced and pos != 0. It is cleared on each received byte.
- If the counter reaches TIMEOUT_CYCLES:
  - pos resets to 0;
  - any pending WR_LEDS commit is discarded;
  - err_count increments.
- Macro undefined: no counter is built, and a partial frame waits indefinitely.

Test Plan:
- Reset, then a bus model acks each access after 2 cycles -> exactly five writes in order: 0x08/0x00, 0x09/0x80, 0x0A/0x01, 0x0B/0x00, 0x0F/0x00; then SPISR polling starts.
- Unsynced: send 0x55 then 0x11 -> synced stays 0 after 0x55 and rises after 0x11; no SPITXDR writes occur before sync.
- Frame 04 05 00 00 00 00 00 00 with NUM_LEDS=3 -> TX replies 40 04 05 00 00 00 00 00; led goes 3'b101 only after byte 7; frame_done pulses once.
- WR_VEC 06 0E 11 22 33 44 55 66, then RD_VEC 07 0E 00 .. with VEC_DEPTH=16 -> read replies bytes 2..7 = 11 22 33 44 55 66, with the wrap 0E,0F,00..03 verified.
- Opcode 0x2A frame, then RD_STATUS -> err_count=1; status reply[1]=0x01, reply[2]=0x80.
- Assert reset while sb_stb=1 mid-frame -> sb_stb=0 next cycle, led=0, synced=0, configuration restarts at CFG_CR0. With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, stall 101 cycles after byte 3 -> pos=0 and err_count increments.
